// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if
//   Bundle of the client-side request/ack signals and the UART-side
//   send signals of the shared-transmitter arbiter.
//
//   master : client/system side. Drives arb_en, req and req_data. Observes
//            ack, the UART outputs and the status.
//   slave  : the arbiter itself.
//
//   Signals
//     arb_en        1 = new grants allowed
//     req           per-requester request level, held until acked
//     req_data      byte of requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//     ack           one-cycle pulse, byte of requester i taken
//     uart_tx_data  byte to the UART top
//     uart_tx_send  one-cycle start pulse to the UART top
//     busy          arbiter not idle
//     grant_id      current/last granted requester
interface uart_tx_arbiter_if #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8
);
   localparam int ID_W = $clog2(NUM_REQ);

   logic                          arb_en;
   logic [NUM_REQ-1:0]            req;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
   logic [NUM_REQ-1:0]            ack;
   logic [DATA_WIDTH-1:0]         uart_tx_data;
   logic                          uart_tx_send;
   logic                          busy;
   logic [ID_W-1:0]               grant_id;

   modport master (
      output arb_en, req, req_data,
      input  ack, uart_tx_data, uart_tx_send, busy, grant_id
   );

   modport slave (
      input  arb_en, req, req_data,
      output ack, uart_tx_data, uart_tx_send, busy, grant_id
   );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one UART transmitter between NUM_REQ requesters. The UART top
//   gives no tx-done, so each frame is timed locally: after a one-cycle
//   send pulse the arbiter waits FRAME_BITS*CLKS_PER_BIT cycles plus a
//   GUARD_CLKS idle gap before the next arbitration.
//
//   Ports
//     clk    system clock
//     n_rst  asynchronous active-low reset
//     bus    uart_tx_arbiter_if.slave (req/req_data/arb_en in,
//            ack/uart_tx_data/uart_tx_send/busy/grant_id out)
//
//   Build option
//     UART_ARB_FIXED_PRIO_EN : when defined, the lowest set req index always
//     wins and no round-robin pointer exists. Default is round-robin.
module uart_tx_arbiter #(
   parameter int NUM_REQ      = 4,
   parameter int DATA_WIDTH   = 8,
   parameter int CLKS_PER_BIT = 434,
   parameter int FRAME_BITS   = 11,
   parameter int GUARD_CLKS   = 2
) (
   input  logic              clk,
   input  logic              n_rst,
   uart_tx_arbiter_if.slave  bus
);
   localparam int ID_W       = $clog2(NUM_REQ);
   localparam int FRAME_CLKS = FRAME_BITS * CLKS_PER_BIT;
   localparam int MAX_CLKS   = (FRAME_CLKS > GUARD_CLKS) ? FRAME_CLKS : GUARD_CLKS;
   localparam int CNT_W      = $clog2(MAX_CLKS + 1);
   localparam int FRAME_LAST = FRAME_CLKS - 1;
   // GUARD is never entered when GUARD_CLKS is 0; keep the constant legal anyway.
   localparam int GUARD_LAST = (GUARD_CLKS > 0) ? GUARD_CLKS - 1 : 0;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SEND  = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;
   localparam logic [1:0] ST_GUARD = 2'd3;

   logic [1:0]            state_reg, state_next;
   logic [CNT_W-1:0]      cnt_reg, cnt_next;
   logic [ID_W-1:0]       grant_reg;
   logic [ID_W-1:0]       winner;
   logic [DATA_WIDTH-1:0] data_reg;
   logic                  send_reg;
   logic                  busy_reg;
   logic                  grant_now;

   // Arbitration only matters in IDLE; everywhere else req is ignored.
   assign grant_now = (state_reg == ST_IDLE) && bus.arb_en && (|bus.req);

`ifdef UART_ARB_FIXED_PRIO_EN
   // Scan from the top down so the lowest set index is the last write.
   always_comb begin
      winner = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (bus.req[k]) winner = ID_W'(k);
      end
   end
`else
   logic [ID_W-1:0] last_reg;

   // First set request after the last served one, wrapping modulo NUM_REQ,
   // so the requester just served has the lowest priority.
   always_comb begin
      logic found;
      int   idx;
      winner = '0;
      found  = 1'b0;
      idx    = 0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = (int'(last_reg) + k) % NUM_REQ;
         if (!found && bus.req[idx]) begin
            found  = 1'b1;
            winner = ID_W'(idx);
         end
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         last_reg <= ID_W'(NUM_REQ - 1);
      end else if (state_reg == ST_SEND) begin
         last_reg <= grant_reg;
      end
   end
`endif

   always_comb begin
      state_next = state_reg;
      cnt_next   = '0;
      case (state_reg)
         ST_IDLE: begin
            if (grant_now) state_next = ST_SEND;
         end
         ST_SEND: begin
            state_next = ST_WAIT;
         end
         ST_WAIT: begin
            cnt_next = cnt_reg + CNT_W'(1);
            if (cnt_reg == CNT_W'(FRAME_LAST))
               state_next = (GUARD_CLKS == 0) ? ST_IDLE : ST_GUARD;
         end
         default: begin
            cnt_next = cnt_reg + CNT_W'(1);
            if (cnt_reg == CNT_W'(GUARD_LAST)) state_next = ST_IDLE;
         end
      endcase
      // Counter restarts from zero on every state entry.
      if (state_next != state_reg) cnt_next = '0;
   end

   // send/busy are registered from the next state so they are clean flop
   // outputs that line up exactly with the SEND / non-IDLE states.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_reg <= ST_IDLE;
         cnt_reg   <= '0;
         grant_reg <= '0;
         data_reg  <= '0;
         send_reg  <= 1'b0;
         busy_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         send_reg  <= (state_next == ST_SEND);
         busy_reg  <= (state_next != ST_IDLE);
         // Byte is captured at the grant decision, so a request dropped
         // before SEND still has its byte sent.
         if (grant_now) begin
            grant_reg <= winner;
            data_reg  <= bus.req_data[winner * DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // One-hot ack: only the granted index can pulse, only during SEND.
   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ack
      assign bus.ack[gi] = send_reg && (grant_reg == ID_W'(gi));
   end

   assign bus.uart_tx_send = send_reg;
   assign bus.uart_tx_data = data_reg;
   assign bus.busy         = busy_reg;
   assign bus.grant_id     = grant_reg;
endmodule
